sfx_sequencer: RTL and testbench

SFX_SEQUENCER -- requirements
Module: sfx_sequencer

---
 rtl/sfx_sequencer.sv | 171 +++++++++++++++++
 tb/tb_sfx_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sfx_sequencer.sv
// rtl/sfx_sequencer.sv - four-sound, four-step tone sequencer with priority triggers
//
// Purpose: plays one of four fixed tone sequences. Each sound has up to four
// (period, duration) steps. Durations are counted in ticks of TICK_DIV clocks.
// Requests are latched in a pending mask and served highest id first.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   trigger    one request bit per sound id (bit 3 = highest priority)
//   period     tone period for the square-wave generator, 0 = silence
//   busy       high while a sound is being loaded or played
//   active_id  id of the sound being sequenced, valid while busy
//
// Build option: SFX_PREEMPT_EN - when defined, a pending request with
// id >= the playing id interrupts PLAY; an equal id restarts the sound.
module sfx_sequencer #(
  parameter int PERIOD_WIDTH = 32,
  parameter int TICK_DIV     = 500000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              trigger,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic                    busy,
  output logic [1:0]              active_id
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY} state_t;

  // TICK_DIV is at most 2^24-1, so a 24-bit tick counter never wraps.
  localparam logic [23:0] TICK_LAST = 24'(TICK_DIV - 1);

  state_t                  state_q;
  logic [3:0]              pending_q;
  logic [3:0]              pending_d;
  logic [1:0]              id_q;
  logic [1:0]              step_q;
  logic [PERIOD_WIDTH-1:0] period_q;
  logic                    busy_q;
  // Longest step in the table is 4 ticks; 3 bits hold 0..7.
  logic [2:0]              dur_q;
  logic [2:0]              dcnt_q;
  logic [23:0]             tick_q;

  logic [16:0] tab_period;
  logic [2:0]  tab_dur;
  logic [1:0]  hi_id;
  logic        pend_any;
  logic        preempt;
  logic        take;
  logic        tick_last;
  logic        dur_last;

  // Sound table, indexed by the sound and step currently held.
  always_comb begin
    tab_period = '0;
    tab_dur    = '0;
    case ({id_q, step_q})
      4'b00_00: begin tab_period = 17'd50000;  tab_dur = 3'd2; end
      4'b01_00: begin tab_period = 17'd20000;  tab_dur = 3'd1; end
      4'b01_01: begin tab_period = 17'd25000;  tab_dur = 3'd1; end
      4'b01_10: begin tab_period = 17'd30000;  tab_dur = 3'd1; end
      4'b10_00: begin tab_period = 17'd60000;  tab_dur = 3'd2; end
      4'b10_01: begin tab_period = 17'd0;      tab_dur = 3'd1; end
      4'b10_10: begin tab_period = 17'd60000;  tab_dur = 3'd2; end
      4'b11_00: begin tab_period = 17'd80000;  tab_dur = 3'd4; end
      4'b11_01: begin tab_period = 17'd90000;  tab_dur = 3'd4; end
      4'b11_10: begin tab_period = 17'd100000; tab_dur = 3'd4; end
      4'b11_11: begin tab_period = 17'd110000; tab_dur = 3'd4; end
      default: ;
    endcase
  end

  // Highest set pending bit; the ascending loop lets higher ids overwrite.
  always_comb begin
    hi_id = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (pending_q[i]) hi_id = 2'(i);
    end
  end

  assign pend_any = |pending_q;

`ifdef SFX_PREEMPT_EN
  // The highest pending id is the one that would be chosen, so comparing it
  // alone covers "any pending id >= active id".
  assign preempt = (state_q == S_PLAY) && pend_any && (hi_id >= id_q);
`else
  assign preempt = 1'b0;
`endif

  assign take = ((state_q == S_IDLE) && pend_any) || preempt;

  // Clear the selected request first, then OR in new triggers so a request
  // sampled on the clearing edge survives.
  always_comb begin
    pending_d = pending_q;
    if (take) pending_d[hi_id] = 1'b0;
    pending_d = pending_d | trigger;
  end

  assign tick_last = (tick_q == TICK_LAST);
  assign dur_last  = (dcnt_q == (dur_q - 3'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      id_q      <= '0;
      step_q    <= '0;
      period_q  <= '0;
      busy_q    <= 1'b0;
      dur_q     <= '0;
      dcnt_q    <= '0;
      tick_q    <= '0;
    end else begin
      pending_q <= pending_d;
      if (take) begin
        // period_q is left alone so it holds through the LOAD cycle.
        state_q <= S_LOAD;
        busy_q  <= 1'b1;
        id_q    <= hi_id;
        step_q  <= 2'd0;
      end else begin
        case (state_q)
          S_IDLE: ;
          S_LOAD: begin
            if (tab_dur == 3'd0) begin
              period_q <= '0;
              busy_q   <= 1'b0;
              state_q  <= S_IDLE;
            end else begin
              period_q <= PERIOD_WIDTH'(tab_period);
              dur_q    <= tab_dur;
              dcnt_q   <= 3'd0;
              tick_q   <= 24'd0;
              state_q  <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (tick_last) begin
              tick_q <= 24'd0;
              if (dur_last) begin
                dcnt_q <= 3'd0;
                if (step_q == 2'd3) begin
                  period_q <= '0;
                  busy_q   <= 1'b0;
                  state_q  <= S_IDLE;
                end else begin
                  step_q  <= step_q + 2'd1;
                  state_q <= S_LOAD;
                end
              end else begin
                dcnt_q <= dcnt_q + 3'd1;
              end
            end else begin
              tick_q <= tick_q + 24'd1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign period    = period_q;
  assign busy      = busy_q;
  assign active_id = id_q;

endmodule

// File: tb/tb_sfx_sequencer.sv
// tb/tb_sfx_sequencer.sv - bench for sfx_sequencer against a per-sound trace model
module tb_sfx_sequencer;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  trigger = 4'd0;
  logic [31:0] period;
  logic        busy;
  logic [1:0]  active_id;

  sfx_sequencer #(.PERIOD_WIDTH(32), .TICK_DIV(TD)) dut (
    .clk       (clk),
    .rst       (rst),
    .trigger   (trigger),
    .period    (period),
    .busy      (busy),
    .active_id (active_id)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  int tp [16] = '{50000, 0, 0, 0,  20000, 25000, 30000, 0,
                  60000, 0, 60000, 0,  80000, 90000, 100000, 110000};
  int td [16] = '{2, 0, 0, 0,  1, 1, 1, 0,  2, 1, 2, 0,  4, 4, 4, 4};

  typedef struct { int p; bit play; } ent_t;
  ent_t       trace[$];
  int         m_period;
  bit         m_busy;
  bit         m_play;
  int         m_id;
  logic [3:0] m_pend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  // Expected per-cycle outputs of one sound from its LOAD cycle onward.
  function automatic void build(input int id, input int prev);
    ent_t e;
    bit   done;
    trace.delete();
    e.p = prev; e.play = 1'b0; trace.push_back(e);
    done = 1'b0;
    for (int s = 0; s < 4; s++) begin
      if (!done) begin
        if (td[id*4+s] == 0) begin
          done = 1'b1;
        end else begin
          repeat (td[id*4+s] * TD) begin
            e.p = tp[id*4+s]; e.play = 1'b1; trace.push_back(e);
          end
          if (s < 3) begin
            e.p = tp[id*4+s]; e.play = 1'b0; trace.push_back(e);
          end
        end
      end
    end
  endfunction

  function automatic void model_edge(input logic [3:0] t);
    int   hi;
    bit   start;
    ent_t e;
    hi = -1;
    for (int i = 0; i < 4; i++) if (m_pend[i]) hi = i;
    start = !m_busy && (hi >= 0);
`ifdef SFX_PREEMPT_EN
    if (m_busy && m_play && hi >= m_id) start = 1'b1;
`endif
    if (start) begin
      m_pend[hi] = 1'b0;
      m_id = hi;
      build(hi, m_period);
    end
    m_pend = m_pend | t;
    if (trace.size() > 0) begin
      e = trace.pop_front();
      m_period = e.p; m_play = e.play; m_busy = 1'b1;
    end else begin
      m_period = 0; m_play = 1'b0; m_busy = 1'b0;
    end
  endfunction

  task automatic step(input logic [3:0] t);
    trigger = t;
    @(posedge clk);
    model_edge(t);
    #1;
    chk("period", period, m_period);
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    if (m_busy) chk("active_id", {30'd0, active_id}, m_id);
  endtask

  task automatic run(input int n);
    repeat (n) step(4'd0);
  endtask

  task automatic do_reset();
    trigger = 4'd0;
    rst = 1'b1;
    #1;
    chk("rst_period", period, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_active_id", {30'd0, active_id}, 0);
    trace.delete();
    m_pend = 4'd0; m_period = 0; m_busy = 1'b0; m_play = 1'b0; m_id = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2;
    do_reset();

    // Single shoot sound: latency and full sequence.
    step(4'b0010);
    chk("trig_busy", {31'd0, busy}, 0);
    step(4'd0);
    chk("load_busy", {31'd0, busy}, 1);
    chk("load_period", period, 0);
    step(4'd0);
    chk("lat_period", period, 20000);
    run(20);
    chk("shoot_end_busy", {31'd0, busy}, 0);
    chk("shoot_end_period", period, 0);

    // Two simultaneous requests: id2 first, id0 afterwards.
    step(4'b0101);
    step(4'd0);
    chk("prio_id", {30'd0, active_id}, 2);
    run(50);
    chk("prio_end_busy", {31'd0, busy}, 0);

    // Higher-priority request while id1 plays.
    step(4'b0010);
    run(3);
    step(4'b1000);
    step(4'd0);
    step(4'd0);
`ifdef SFX_PREEMPT_EN
    chk("preempt_id", {30'd0, active_id}, 3);
    chk("preempt_period", period, 80000);
`else
    chk("nopreempt_id", {30'd0, active_id}, 1);
    chk("nopreempt_period", period, 20000);
`endif
    run(120);
    chk("preempt_end_busy", {31'd0, busy}, 0);

    // Reset during id3 step 1, then silence without a new trigger.
    step(4'b1000);
    run(1 + 16 + 1 + 3);
    chk("death_step1_period", period, 90000);
    do_reset();
    run(10);
    chk("post_rst_busy", {31'd0, busy}, 0);

    // Trigger held on the selection edge: id1 plays twice.
    step(4'b0010);
    step(4'b0010);
    step(4'd0);
    run(16);
    chk("repeat_busy", {31'd0, busy}, 1);
    chk("repeat_id", {30'd0, active_id}, 1);
    run(30);
    chk("repeat_end_busy", {31'd0, busy}, 0);

    // Random triggers with occasional resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else if ($urandom_range(0, 11) == 0) step(4'($urandom_range(1, 15)));
      else step(4'd0);
    end
    run(150);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
